// File: rtl/fpu_pkg.sv
// Shared FPU definitions: operation codes, the align-prep buffer entry and
// the alignment shift saturation limit.
package fpu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_MUL  = 3'd2,
    OP_DIV  = 3'd3,
    OP_SQRT = 3'd4,
    OP_MIN  = 3'd5,
    OP_MAX  = 3'd6,
    OP_CMP  = 3'd7
  } fpu_op_t;

  localparam int ALIGN_SHIFT_MAX = 31;

  typedef struct packed {
    fpu_op_t     op;
    logic        exchange;
    logic [4:0]  shift;
    logic        eff_sub;
    logic        sign_a;
    logic        sign_b;
    logic [7:0]  exp_a;
    logic [7:0]  exp_b;
    logic [23:0] frac_a;
    logic [23:0] frac_b;
  } align_prep_t;

  function automatic logic is_add_sub(fpu_op_t op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/exponent_comparator.sv
// Combinational operand ordering, saturated alignment shift and effective
// subtraction decision for the add/sub path.
module exponent_comparator
  import fpu_pkg::*;
#(
  parameter int SHIFT_MAX = ALIGN_SHIFT_MAX
) (
  input  fpu_op_t     op,
  input  logic        sign_a,
  input  logic        sign_b,
  input  logic [7:0]  exponent_a,
  input  logic [7:0]  exponent_b,
  input  logic [23:0] fraction_a,
  input  logic [23:0] fraction_b,
  output logic        sign_b_eff,
  output logic        exchange_operands,
  output logic [4:0]  align_shift_count,
  output logic        effective_subtract
);

  logic       b_larger;
  logic [8:0] diff;

  always_comb begin
    sign_b_eff         = sign_b ^ (op == OP_SUB);
    b_larger           = (exponent_b > exponent_a) ||
                         ((exponent_b == exponent_a) && (fraction_b > fraction_a));
    diff               = (exponent_a >= exponent_b) ?
                         ({1'b0, exponent_a} - {1'b0, exponent_b}) :
                         ({1'b0, exponent_b} - {1'b0, exponent_a});
    exchange_operands  = 1'b0;
    align_shift_count  = 5'd0;
    effective_subtract = 1'b0;
    if (is_add_sub(op)) begin
      exchange_operands  = b_larger;
      align_shift_count  = (diff > 9'(SHIFT_MAX)) ? 5'(SHIFT_MAX) : diff[4:0];
      effective_subtract = sign_a ^ sign_b_eff;
    end
  end

endmodule

// File: rtl/align_prep_stage.sv
// Align-prep pipeline stage: operand comparison results registered behind a
// two-entry (main + skid) valid/ready buffer.
module align_prep_stage
  import fpu_pkg::*;
#(
  parameter int SHIFT_MAX = ALIGN_SHIFT_MAX
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic        sign_a,
  input  logic        sign_b,
  input  logic [7:0]  exponent_a,
  input  logic [7:0]  exponent_b,
  input  logic [23:0] fraction_a,
  input  logic [23:0] fraction_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  out_op,
  output logic        exchange_operands,
  output logic [4:0]  align_shift_count,
  output logic        effective_subtract,
  output logic        out_sign_a,
  output logic        out_sign_b,
  output logic [7:0]  out_exponent_a,
  output logic [7:0]  out_exponent_b,
  output logic [23:0] out_fraction_a,
  output logic [23:0] out_fraction_b
);

  fpu_op_t     op;
  logic        sign_b_eff;
  logic        cmp_exchange;
  logic [4:0]  cmp_shift;
  logic        cmp_eff_sub;
  align_prep_t new_entry;

  align_prep_t main_q, main_d;
  align_prep_t skid_q, skid_d;
  logic        main_valid_q, main_valid_d;
  logic        skid_valid_q, skid_valid_d;
  logic        in_ready_q, in_ready_d;
  logic        accept;
  logic        drain;

  assign op = fpu_op_t'(in_op);

  exponent_comparator #(
    .SHIFT_MAX(SHIFT_MAX)
  ) u_cmp (
    .op                (op),
    .sign_a            (sign_a),
    .sign_b            (sign_b),
    .exponent_a        (exponent_a),
    .exponent_b        (exponent_b),
    .fraction_a        (fraction_a),
    .fraction_b        (fraction_b),
    .sign_b_eff        (sign_b_eff),
    .exchange_operands (cmp_exchange),
    .align_shift_count (cmp_shift),
    .effective_subtract(cmp_eff_sub)
  );

  always_comb begin
    new_entry.op       = op;
    new_entry.exchange = cmp_exchange;
    new_entry.shift    = cmp_shift;
    new_entry.eff_sub  = cmp_eff_sub;
    new_entry.sign_a   = sign_a;
    new_entry.sign_b   = sign_b_eff;
    new_entry.exp_a    = exponent_a;
    new_entry.exp_b    = exponent_b;
    new_entry.frac_a   = fraction_a;
    new_entry.frac_b   = fraction_b;
  end

  // Main always holds the oldest entry; skid only fills when main is stuck.
  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    accept       = in_valid && in_ready_q;
    drain        = main_valid_q && out_ready;

    if (drain) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = 1'b0;
      end
    end

    if (accept) begin
      if (!main_valid_q || (drain && !skid_valid_q)) begin
        main_d       = new_entry;
        main_valid_d = 1'b1;
      end else begin
        skid_d       = new_entry;
        skid_valid_d = 1'b1;
      end
    end

    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready           = in_ready_q;
  assign out_valid          = main_valid_q;
  assign out_op             = main_q.op;
  assign exchange_operands  = main_q.exchange;
  assign align_shift_count  = main_q.shift;
  assign effective_subtract = main_q.eff_sub;
  assign out_sign_a         = main_q.sign_a;
  assign out_sign_b         = main_q.sign_b;
  assign out_exponent_a     = main_q.exp_a;
  assign out_exponent_b     = main_q.exp_b;
  assign out_fraction_a     = main_q.frac_a;
  assign out_fraction_b     = main_q.frac_b;

endmodule

// File: tb/tb_align_prep_stage.sv
// Self-checking bench for align_prep_stage: directed cases plus a randomized
// handshake run against a queue-based reference model.
module tb_align_prep_stage;
  import fpu_pkg::*;

  typedef struct packed {
    logic [2:0]  op;
    logic        exch;
    logic [4:0]  shift;
    logic        eff;
    logic        sa;
    logic        sb;
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic [23:0] fa;
    logic [23:0] fb;
  } tb_entry_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = 3'd0;
  logic        sign_a = 1'b0, sign_b = 1'b0;
  logic [7:0]  exponent_a = 8'd0, exponent_b = 8'd0;
  logic [23:0] fraction_a = 24'd0, fraction_b = 24'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [2:0]  out_op;
  logic        exchange_operands;
  logic [4:0]  align_shift_count;
  logic        effective_subtract;
  logic        out_sign_a, out_sign_b;
  logic [7:0]  out_exponent_a, out_exponent_b;
  logic [23:0] out_fraction_a, out_fraction_b;

  int total = 0;
  int bad = 0;

  tb_entry_t model_q[$];
  logic      exp_in_ready = 1'b1;

  align_prep_stage dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_op             (in_op),
    .sign_a            (sign_a),
    .sign_b            (sign_b),
    .exponent_a        (exponent_a),
    .exponent_b        (exponent_b),
    .fraction_a        (fraction_a),
    .fraction_b        (fraction_b),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_op            (out_op),
    .exchange_operands (exchange_operands),
    .align_shift_count (align_shift_count),
    .effective_subtract(effective_subtract),
    .out_sign_a        (out_sign_a),
    .out_sign_b        (out_sign_b),
    .out_exponent_a    (out_exponent_a),
    .out_exponent_b    (out_exponent_b),
    .out_fraction_a    (out_fraction_a),
    .out_fraction_b    (out_fraction_b)
  );

  always #5 clk = ~clk;

  // Expected entry computed from the arithmetic rules with plain integers.
  function automatic tb_entry_t predict();
    tb_entry_t e;
    int d;
    bit addsub;
    addsub = (in_op == 3'd0) || (in_op == 3'd1);
    d = int'(exponent_a) - int'(exponent_b);
    if (d < 0) d = -d;
    e.op    = in_op;
    e.sa    = sign_a;
    e.sb    = sign_b ^ (in_op == 3'd1);
    e.ea    = exponent_a;
    e.eb    = exponent_b;
    e.fa    = fraction_a;
    e.fb    = fraction_b;
    e.exch  = addsub && ((int'(exponent_b) > int'(exponent_a)) ||
              (exponent_b == exponent_a && fraction_b > fraction_a));
    e.shift = addsub ? 5'((d > 31) ? 31 : d) : 5'd0;
    e.eff   = addsub && (e.sa != e.sb);
    return e;
  endfunction

  function automatic tb_entry_t observed();
    tb_entry_t o;
    o = '{out_op, exchange_operands, align_shift_count, effective_subtract,
          out_sign_a, out_sign_b, out_exponent_a, out_exponent_b,
          out_fraction_a, out_fraction_b};
    return o;
  endfunction

  // Advance one clock and update the FIFO model from this cycle's handshakes.
  task automatic tick();
    bit acc, drn;
    tb_entry_t e;
    acc = in_valid && exp_in_ready && !reset;
    drn = (model_q.size() > 0) && out_ready;
    e = predict();
    @(posedge clk);
    #1;
    if (reset) begin
      model_q.delete();
      exp_in_ready = 1'b1;
    end else begin
      if (drn) void'(model_q.pop_front());
      if (acc) model_q.push_back(e);
      exp_in_ready = (model_q.size() < 2);
    end
  endtask

  task automatic drive_op(input logic [2:0] op, input logic sa, input logic sb,
                          input logic [7:0] ea, input logic [7:0] eb,
                          input logic [23:0] fa, input logic [23:0] fb);
    in_op = op; sign_a = sa; sign_b = sb;
    exponent_a = ea; exponent_b = eb; fraction_a = fa; fraction_b = fb;
  endtask

  task automatic drain_all();
    int n;
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (model_q.size() > 0 && n < 10) begin
      tick();
      n++;
    end
    if (model_q.size() > 0) begin
      total++; bad++;
      $display("[TB] FAIL drain_timeout: model still holds %0d entries, required 0", model_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b1;
    tick(); tick();
    reset = 1'b0;
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid: got %b, required 0", out_valid); end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready: got %b, required 1", in_ready); end
    total++;
    if (observed() !== '0) begin bad++; $display("[TB] FAIL reset_data: got %h, required 0", observed()); end
    tick();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_no_accept: got out_valid %b, required 0", out_valid); end
  endtask

  task automatic test_add_small_diff();
    drive_op(3'd0, 1'b0, 1'b0, 8'd130, 8'd127, 24'h800000, 24'h800000);
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || exchange_operands !== 1'b0 || align_shift_count !== 5'd3 ||
        effective_subtract !== 1'b0)
    begin
      bad++;
      $display("[TB] FAIL add_small_diff: got v=%b x=%b s=%0d e=%b, required v=1 x=0 s=3 e=0",
               out_valid, exchange_operands, align_shift_count, effective_subtract);
    end
    drain_all();
  endtask

  task automatic test_add_saturated();
    drive_op(3'd0, 1'b0, 1'b0, 8'd100, 8'd140, 24'h900000, 24'hA00000);
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || exchange_operands !== 1'b1 || align_shift_count !== 5'd31) begin
      bad++;
      $display("[TB] FAIL add_saturated: got v=%b x=%b s=%0d, required v=1 x=1 s=31",
               out_valid, exchange_operands, align_shift_count);
    end
    drain_all();
  endtask

  task automatic test_sub_equal_exp();
    drive_op(3'd1, 1'b0, 1'b0, 8'd127, 8'd127, 24'h800000, 24'hC00000);
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    total++;
    if (exchange_operands !== 1'b1 || align_shift_count !== 5'd0 || out_sign_b !== 1'b1 ||
        effective_subtract !== 1'b1)
    begin
      bad++;
      $display("[TB] FAIL sub_equal_exp: got x=%b s=%0d sb=%b e=%b, required x=1 s=0 sb=1 e=1",
               exchange_operands, align_shift_count, out_sign_b, effective_subtract);
    end
    // Equal magnitudes must not exchange.
    drive_op(3'd1, 1'b0, 1'b1, 8'd90, 8'd90, 24'hABCDEF, 24'hABCDEF);
    tick();
    in_valid = 1'b0;
    total++;
    if (exchange_operands !== 1'b0 || out_sign_b !== 1'b0 || effective_subtract !== 1'b0) begin
      bad++;
      $display("[TB] FAIL sub_equal_mag: got x=%b sb=%b e=%b, required x=0 sb=0 e=0",
               exchange_operands, out_sign_b, effective_subtract);
    end
    drain_all();
  endtask

  task automatic test_mul_passthrough();
    drive_op(3'd2, 1'b1, 1'b1, 8'd10, 8'd200, 24'h812345, 24'hF00001);
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    total++;
    if (exchange_operands !== 1'b0 || align_shift_count !== 5'd0 || effective_subtract !== 1'b0 ||
        out_op !== 3'd2 || out_sign_b !== 1'b1 || out_exponent_a !== 8'd10 ||
        out_exponent_b !== 8'd200 || out_fraction_a !== 24'h812345 || out_fraction_b !== 24'hF00001)
    begin
      bad++;
      $display("[TB] FAIL mul_passthrough: got %h, required op=2 x=0 s=0 e=0 operands unchanged",
               observed());
    end
    drain_all();
  endtask

  task automatic test_back_to_back();
    tb_entry_t sent[3];
    int got, n;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_op(3'd0, 1'b0, 1'(i), 8'(120 + i), 8'd118, 24'(24'h800001 + i), 24'h900000);
      sent[i] = predict();
      in_valid = 1'b1;
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL b2b_ready_op%0d: got %b, required 1", i + 1, in_ready); end
      tick();
    end
    drive_op(3'd1, 1'b1, 1'b0, 8'd122, 8'd130, 24'h800003, 24'h900000);
    sent[2] = predict();
    for (int c = 0; c < 2; c++) begin
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL b2b_stall_c%0d: in_ready got %b, required 0", c + 3, in_ready); end
      tick();
    end
    out_ready = 1'b1;
    got = 0;
    n = 0;
    while (got < 3 && n < 20) begin
      if (out_valid === 1'b1) begin
        total++;
        if (observed() !== sent[got]) begin
          bad++;
          $display("[TB] FAIL b2b_order_%0d: got %h, required %h", got + 1, observed(), sent[got]);
        end
        got++;
      end
      if (in_valid && exp_in_ready) begin
        tick();
        in_valid = 1'b0;
      end else begin
        tick();
      end
      n++;
    end
    total++;
    if (got != 3) begin bad++; $display("[TB] FAIL b2b_count: got %0d outputs, required 3", got); end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_duplicate: out_valid got %b, required 0", out_valid); end
    drain_all();
  endtask

  task automatic test_reset_full();
    out_ready = 1'b0;
    in_valid = 1'b1;
    drive_op(3'd0, 1'b1, 1'b0, 8'd50, 8'd60, 24'hC00000, 24'h800000);
    tick(); tick();
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL full_before_reset: in_ready got %b, required 0", in_ready); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || observed() !== '0) begin
      bad++;
      $display("[TB] FAIL reset_full: got v=%b r=%b data=%h, required v=0 r=1 data=0",
               out_valid, in_ready, observed());
    end
    drain_all();
  endtask

  task automatic test_random();
    logic [7:0] ea, eb;
    logic [23:0] fa, fb;
    for (int c = 0; c < 600; c++) begin
      ea = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 3))
        0: eb = ea;
        1: eb = 8'(ea + 8'($urandom_range(0, 40)));
        2: eb = 8'(ea - 8'($urandom_range(0, 40)));
        default: eb = 8'($urandom_range(0, 255));
      endcase
      fa = {1'b1, 23'($urandom)};
      fb = ($urandom_range(0, 3) == 0) ? fa : {1'b1, 23'($urandom)};
      drive_op(($urandom_range(0, 3) != 0) ? 3'($urandom_range(0, 1)) : 3'($urandom_range(2, 7)),
               1'($urandom), 1'($urandom), ea, eb, fa, fb);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      total++;
      if (out_valid !== (model_q.size() > 0)) begin
        bad++;
        $display("[TB] FAIL rand_valid c%0d: got %b, required %b", c, out_valid, model_q.size() > 0);
      end
      total++;
      if (in_ready !== exp_in_ready) begin
        bad++;
        $display("[TB] FAIL rand_ready c%0d: got %b, required %b", c, in_ready, exp_in_ready);
      end
      if (model_q.size() > 0) begin
        total++;
        if (observed() !== model_q[0]) begin
          bad++;
          $display("[TB] FAIL rand_data c%0d: got %h, required %h", c, observed(), model_q[0]);
        end
      end
      tick();
    end
    drain_all();
  endtask

  initial begin
    test_reset();
    test_add_small_diff();
    test_add_saturated();
    test_sub_equal_exp();
    test_mul_passthrough();
    test_back_to_back();
    test_reset_full();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/align_prep_stage.md
# align_prep_stage

Pipeline stage directly upstream of the aligner in the FPU add/sub path. It compares the unpacked operand exponents and fractions and decides whether the operands must be exchanged. It computes the saturated alignment shift count, applies the subtract sign flip and flags an effective subtraction. Results are registered behind a two-entry skid buffer with a valid/ready handshake, so backpressure from the aligner stage never drops or reorders operations.

## Interface

Parameters:
- `SHIFT_MAX`, default 31: saturation value of `align_shift_count`; must fit in 5 bits.

Ports:
- `clk`  input  1  clock
- `reset`  input  1  synchronous, active-high reset
- `in_valid`  input  1  upstream has an operation
- `in_ready`  output  1  stage can accept; registered
- `in_op`  input  3  `fpu_op_t` operation code
- `sign_a`, `sign_b`  input  1  operand signs
- `exponent_a`, `exponent_b`  input  8  biased exponents
- `fraction_a`, `fraction_b`  input  24  fractions with hidden bit, [x.xxx…]
- `out_valid`  output  1  result available
- `out_ready`  input  1  aligner stage accepts
- `out_op`  output  3  operation passed through
- `exchange_operands`  output  1  aligner must swap A/B
- `align_shift_count`  output  5  right-shift for the smaller operand
- `effective_subtract`  output  1  magnitudes are subtracted
- `out_sign_a`, `out_sign_b`, `out_exponent_a`, `out_exponent_b`, `out_fraction_a`, `out_fraction_b`  output  1/8/24  operands in input order, unsorted; `out_sign_b` is already flipped for SUB

## Operation

- One clock domain; reset is synchronous and active-high.
- `sign_b_eff` = `sign_b ^ (in_op == OP_SUB)`.
- For ADD/SUB:
  - `diff` = |`exponent_a` − `exponent_b`|, computed 9 bits wide.
  - `exchange_operands` = (`exponent_b` > `exponent_a`) or (exponents equal and `fraction_b` > `fraction_a`).
  - `align_shift_count` = min(`diff`, `SHIFT_MAX`).
  - `effective_subtract` = `sign_a ^ sign_b_eff`.
- For all other ops, `exchange_operands`, `align_shift_count` and `effective_subtract` are 0, and operands pass through unchanged.
- Equal magnitudes on ADD/SUB: `exchange_operands` = 0.
- Storage is a two-entry skid buffer: a main (output) register and a skid register.
- Accept condition: `in_valid && in_ready`.
- Data path on accept:
  - If main is empty, or main drains this cycle (`out_ready`), the new entry goes to main.
  - Otherwise it goes to skid.
- When main drains and skid is full, skid moves to main in the same cycle.
- `in_ready` next = skid empty after this cycle's updates.
- Order is strictly FIFO.

## Timing

- Latency: 1 cycle from accept to `out_valid` when the buffer is empty.
- Throughput: 1 op/cycle with `out_ready` held high.
- Reset values:
  - `out_valid` = 0, `in_ready` = 1, skid empty.
  - All data outputs 0.
- Reset mid-operation: both entries are discarded the following cycle. An `in_valid` asserted during reset is not accepted.
- Outputs are stable while `out_valid && !out_ready`.
- Simultaneous accept and drain with skid full: skid → main, and the new entry → skid. This cannot occur, because `in_ready` = 0 whenever skid is full.
- `in_ready` falls in the cycle after the skid register fills. It rises in the cycle after skid is emptied.

## Structure

- Shared package `fpu_pkg`:
  - `fpu_op_t` (OP_ADD, OP_SUB, OP_MUL, OP_DIV, …)
  - packed struct `align_prep_t` holding one buffer entry
  - constant `ALIGN_SHIFT_MAX = 31`
- One natural sub-module: `exponent_comparator`. It is combinational and produces `exchange_operands`, the saturated `align_shift_count` and `effective_subtract` from the inputs.
- The skid buffer stays in the top module.

## Test plan

- ADD, exp_a=130, exp_b=127, both signs 0 → after 1 cycle: exchange=0, shift=3, effective_subtract=0.
- ADD, exp_a=100, exp_b=140 → exchange=1, shift=31 (diff 40 saturated).
- SUB, exponents 127/127, frac_a=0x800000, frac_b=0xC00000, both signs 0 → exchange=1, shift=0, out_sign_b=1, effective_subtract=1.
- MUL, exp_a=10, exp_b=200 → exchange=0, shift=0, operands unchanged.
- `out_ready`=0 for 4 cycles while three ops are offered back-to-back → two ops accepted and `in_ready`=0 from cycle 3. After release, outputs appear in order op1, op2, op3 with no loss or duplication.
- Both entries full, `reset` pulsed 1 cycle → next cycle `out_valid`=0, `in_ready`=1, data outputs 0.
